// File: rtl/serial_add_sequencer.sv
// Bit-serial sequencer for a pipelined 1-bit full adder: issues operand bits LSB-first,
// keeps a single bit in flight, and chains each captured cout into the next bit's cin.
module serial_add_sequencer #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ISSUE   = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             carry_out_q, carry_out_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_shifted;

  // New sum bit enters at the MSB so that after WIDTH captures bit 0 sits at the LSB.
  assign sum_shifted = WIDTH'({fa_sum, sum_sr_q} >> 1);

  always_comb begin
    state_d     = state_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    sum_sr_d    = sum_sr_q;
    result_d    = result_q;
    carry_d     = carry_q;
    carry_out_d = carry_out_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          opa_d    = op_a;
          opb_d    = op_b;
          carry_d  = carry_in;
          idx_d    = '0;
          sum_sr_d = '0;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = (LATENCY > 1) ? ST_WAIT : ST_CAPTURE;
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        sum_sr_d = sum_shifted;
        carry_d  = fa_cout;
        opa_d    = opa_q >> 1;
        opb_d    = opb_q >> 1;
        if (idx_q == IDX_LAST) begin
          // Publish only the complete word; intermediate sums stay internal.
          result_d    = sum_shifted;
          carry_out_d = fa_cout;
          state_d     = ST_DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = ST_ISSUE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      opa_q       <= '0;
      opb_q       <= '0;
      sum_sr_q    <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      idx_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      sum_sr_q    <= sum_sr_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
    end
  end

  // Adder strobes are gated by ISSUE so nothing but the current bit ever enters the adder.
  assign fa_a      = (state_q == ST_ISSUE) & opa_q[0];
  assign fa_b      = (state_q == ST_ISSUE) & opb_q[0];
  assign fa_cin    = (state_q == ST_ISSUE) & carry_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign result    = result_q;
  assign carry_out = carry_out_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Scoreboard bench for serial_add_sequencer: two instances (8-bit/latency 3 and 4-bit/latency 1)
// each driving a behavioural delayed full adder, checked against arithmetic expectations.
module tb_serial_add_sequencer;

  localparam int W0 = 8;
  localparam int L0 = 3;
  localparam int W1 = 4;
  localparam int L1 = 1;
  localparam int TOT0 = W0 * (L0 + 1) + 1;
  localparam int TOT1 = W1 * (L1 + 1) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  logic          start0 = 1'b0;
  logic [W0-1:0] opa0 = '0;
  logic [W0-1:0] opb0 = '0;
  logic          ci0 = 1'b0;
  logic          busy0, done0, cout0, fa_a0, fa_b0, fa_cin0, fa_sum0, fa_cout0;
  logic [W0-1:0] res0;

  logic          start1 = 1'b0;
  logic [W1-1:0] opa1 = '0;
  logic [W1-1:0] opb1 = '0;
  logic          ci1 = 1'b0;
  logic          busy1, done1, cout1, fa_a1, fa_b1, fa_cin1, fa_sum1, fa_cout1;
  logic [W1-1:0] res1;

  serial_add_sequencer #(.WIDTH(W0), .LATENCY(L0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .op_a(opa0), .op_b(opb0), .carry_in(ci0),
    .busy(busy0), .done(done0), .result(res0), .carry_out(cout0),
    .fa_a(fa_a0), .fa_b(fa_b0), .fa_cin(fa_cin0), .fa_sum(fa_sum0), .fa_cout(fa_cout0)
  );

  serial_add_sequencer #(.WIDTH(W1), .LATENCY(L1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op_a(opa1), .op_b(opb1), .carry_in(ci1),
    .busy(busy1), .done(done1), .result(res1), .carry_out(cout1),
    .fa_a(fa_a1), .fa_b(fa_b1), .fa_cin(fa_cin1), .fa_sum(fa_sum1), .fa_cout(fa_cout1)
  );

  // Full adder whose result appears LATENCY cycles after the input strobe.
  function automatic logic [1:0] fa_fn(input logic a, input logic b, input logic c);
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

  logic [1:0] pipe0 [L0];
  logic [1:0] pipe1 [L1];
  always @(posedge clk) begin
    pipe0[0] <= fa_fn(fa_a0, fa_b0, fa_cin0);
    for (int i = 1; i < L0; i++) pipe0[i] <= pipe0[i-1];
    pipe1[0] <= fa_fn(fa_a1, fa_b1, fa_cin1);
  end
  assign {fa_cout0, fa_sum0} = pipe0[L0-1];
  assign {fa_cout1, fa_sum1} = pipe1[L1-1];

  // Adder strobes expected at cycle rel after accept: bit k of a/b plus carry into bit k.
  function automatic logic [2:0] exp_fa(input int rel, input int w, input int l,
                                        input int a, input int b, input int ci);
    int k;
    int m;
    if (rel < 1 || rel > w * (l + 1) || ((rel - 1) % (l + 1)) != 0) return 3'b000;
    k = (rel - 1) / (l + 1);
    m = (1 << k) - 1;
    return {1'(a >> k), 1'(b >> k), 1'((((a & m) + (b & m) + ci) >> k))};
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, got, exp);
  endtask

  // Reference model: decides acceptance from the handshake rules and pushes expected sums.
  int q0[$];
  int q1[$];
  bit act0 = 1'b0, act1 = 1'b0;
  int t0_0, t0_1, a0_m, b0_m, c0_m, a1_m, b1_m, c1_m;
  int cur0, cur1;
  int held0 = 0, held1 = 0;

  always @(posedge clk) begin : model
    if (!rst_n) begin
      if (act0) void'(q0.pop_back());
      if (act1) void'(q1.pop_back());
      act0 = 1'b0; act1 = 1'b0;
      held0 = 0;   held1 = 0;
    end else begin
      if (act0) begin
        if (cyc == t0_0 + TOT0) begin held0 = cur0; act0 = 1'b0; end
      end else if (start0) begin
        a0_m = int'(opa0); b0_m = int'(opb0); c0_m = int'(ci0);
        cur0 = a0_m + b0_m + c0_m;
        t0_0 = cyc; act0 = 1'b1;
        q0.push_back(cur0);
      end
      if (act1) begin
        if (cyc == t0_1 + TOT1) begin held1 = cur1; act1 = 1'b0; end
      end else if (start1) begin
        a1_m = int'(opa1); b1_m = int'(opb1); c1_m = int'(ci1);
        cur1 = a1_m + b1_m + c1_m;
        t0_1 = cyc; act1 = 1'b1;
        q1.push_back(cur1);
      end
    end
  end

  // Monitor: per-cycle protocol checks, and pops the scoreboard whenever a DUT raises done.
  always @(negedge clk) begin : monitor
    int rel;
    int e;
    if (chk_en) begin
      rel = cyc - t0_0;
      check("busy0", int'(busy0), int'(act0));
      check("done0", int'(done0), int'(act0 && rel == TOT0));
      check("fa0", int'({fa_a0, fa_b0, fa_cin0}),
            act0 ? int'(exp_fa(rel, W0, L0, a0_m, b0_m, c0_m)) : 0);
      if (done0) begin
        check("pop0", q0.size(), 1);
        if (q0.size() > 0) begin
          e = q0.pop_front();
          check("result0", int'({cout0, res0}), e);
        end
      end else begin
        check("hold0", int'({cout0, res0}), held0);
      end

      rel = cyc - t0_1;
      check("busy1", int'(busy1), int'(act1));
      check("done1", int'(done1), int'(act1 && rel == TOT1));
      check("fa1", int'({fa_a1, fa_b1, fa_cin1}),
            act1 ? int'(exp_fa(rel, W1, L1, a1_m, b1_m, c1_m)) : 0);
      if (done1) begin
        check("pop1", q1.size(), 1);
        if (q1.size() > 0) begin
          e = q1.pop_front();
          check("result1", int'({cout1, res1}), e);
        end
      end else begin
        check("hold1", int'({cout1, res1}), held1);
      end
    end
  end

  task automatic wait_idle0();
    for (int i = 0; i < 4 * TOT0 && act0; i++) begin @(posedge clk); #2; end
  endtask

  task automatic wait_idle1();
    for (int i = 0; i < 4 * TOT1 && act1; i++) begin @(posedge clk); #2; end
  endtask

  task automatic run0(input int a, input int b, input int ci);
    start0 = 1'b1; opa0 = W0'(a); opb0 = W0'(b); ci0 = 1'(ci);
    @(posedge clk); #2;
    start0 = 1'b0;
    wait_idle0();
  endtask

  task automatic run1(input int a, input int b, input int ci);
    start1 = 1'b1; opa1 = W1'(a); opb1 = W1'(b); ci1 = 1'(ci);
    @(posedge clk); #2;
    start1 = 1'b0;
    wait_idle1();
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (2) begin @(posedge clk); #2; end

    run0('h05, 'h03, 0);
    run0('hFF, 'h01, 0);
    run0('hFF, 'hFF, 1);
    repeat (6) run0(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 1)));

    // Start held high with operands changing every cycle.
    start0 = 1'b1;
    for (int i = 0; i < 80; i++) begin
      opa0 = W0'($urandom); opb0 = W0'($urandom); ci0 = 1'($urandom);
      @(posedge clk); #2;
    end
    start0 = 1'b0;
    wait_idle0();

    // Abort during bit 3, then a clean operation afterwards.
    start0 = 1'b1; opa0 = 8'hAA; opb0 = 8'h55; ci0 = 1'b1;
    @(posedge clk); #2;
    start0 = 1'b0;
    repeat (13) begin @(posedge clk); #2; end
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    run0('h10, 'h20, 0);

    run1('h9, 'h8, 0);
    repeat (8) run1(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 1)));
    start1 = 1'b1;
    for (int i = 0; i < 25; i++) begin
      opa1 = W1'($urandom); opb1 = W1'($urandom); ci1 = 1'($urandom);
      @(posedge clk); #2;
    end
    start1 = 1'b0;
    wait_idle1();

    repeat (3) begin @(posedge clk); #2; end
    check("drained0", q0.size(), 0);
    check("drained1", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
